cory_axi_ram: RTL and testbench
===============================

Name: cory_axi_ram

Overview:
- Synthesizable AXI-style slave memory; the downstream stage of cory_queue_axi.
- Terminates its AW/W/B and AR/R channels, so the queue can spill to and refill from on-chip RAM without an external memory model.
- Services one burst at a time: single-port storage, INCR bursts only, fixed data width.

Parameters:
- A, 32, address width in bits
- D, 64, data width in bits; byte offset bits BL = log2(D/8)
- L, 4, burst length field width; beats = len+1
- M, 10, log2 of storage depth in D-bit words

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-high (block is held in reset while reset_n=1)
- i_aw_v  in  1  write address valid
- i_aw_a  in  A  write byte address
- i_aw_l  in  L  write burst length-1
- o_aw_r  out  1  write address ready
- i_w_v  in  1  write data valid
- i_w_d  in  D  write data
- i_w_l  in  1  write last
- o_w_r  out  1  write data ready
- o_b_v  out  1  write response valid
- i_b_r  in  1  write response ready
- i_ar_v  in  1  read address valid
- i_ar_a  in  A  read byte address
- i_ar_l  in  L  read burst length-1
- o_ar_r  out  1  read address ready
- o_r_v  out  1  read data valid
- o_r_d  out  D  read data
- o_r_l  out  1  read last
- i_r_r  in  1  read data ready
- o_busy  out  1  FSM not in IDLE
- o_err  out  1  sticky protocol error flag

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counters 0, priority=write-first. Storage contents are not reset.
- Handshake: a transfer occurs on a cycle with valid&&ready. Valid/data from this block hold until accepted.
- FSM states: IDLE, WR, WRESP, RD.
- IDLE arbitration:
  - o_aw_r/o_ar_r are combinational in IDLE only, never both high.
  - Only aw_v set -> grant write. Only ar_v set -> grant read.
  - Both set -> grant the side opposite the last granted; priority toggles on every grant.
- On accept: latch word index = a[BL+M-1:BL] and len.
  - Write -> WR.
  - Read -> RD; storage read issued the same cycle.
- WR:
  - o_w_r=1; each w beat writes the current index, then index+1 and beat_cnt+1.
  - Index wraps modulo 2^M with no error.
  - At beat_cnt==len -> WRESP.
  - If i_w_l disagrees with (beat_cnt==len) on any beat, o_err is set; beat count alone ends the burst.
- WRESP: o_b_v=1 until i_b_r, then IDLE. W beats arriving here are not accepted (o_w_r=0).
- RD:
  - o_r_v rises the cycle after ar accept (latency 1); o_r_d is registered.
  - o_r_l = (beat_cnt==len).
  - On r accept: not last -> next word loaded the same cycle, o_r_v stays high (full throughput); last -> IDLE, o_r_v=0.
  - Stalled i_r_r holds o_r_d/o_r_l stable.
- Timing: no combinational path from input valid to output valid. Read-to-write turnaround is at least 1 IDLE cycle.
- Addresses are word-aligned; low BL bits are ignored.
- o_err clears only on reset.
- Reset mid-burst: FSM returns to IDLE, the burst is dropped, and no b/r response is issued for it.

Optional Feature:
- Macro: CORY_AXI_RAM_WSTRB_EN.
- Defined: adds port i_w_s (in, D/8, byte strobes). Only bytes with i_w_s[k]=1 are written; others keep their old value.
- Undefined: no i_w_s port; every accepted beat writes all bytes.

Decomposition:
- Package cory_axi_ram_pkg holds:
  - FSM state encoding (IDLE, WR, WRESP, RD)
  - BL derivation function
  - constants for the priority encoding
- One sub-module, cory_axi_ram_mem: 2^M x D array, one write port (optional byte enables), one registered read port with read-enable. Keeps the storage inferable as block RAM.

Test Plan:
- Write 4 beats (aw_a=0x100, aw_l=3, data 1..4) then read the same address with ar_l=3 -> r beats 1,2,3,4; r_l only on beat 4; one b_v pulse; o_err=0.
- aw_v and ar_v asserted together for 4 rounds from reset -> grants in order W,R,W,R; o_aw_r and o_ar_r never high together.
- Read 8 beats with i_r_r toggling 1,0,1,0 -> o_r_d held during stalls; 8 beats delivered in order; o_r_v continuous while i_r_r=1.
- Write M=10 burst at word 1022, aw_l=3 -> words 1022,1023,0,1 written; read-back at word 0 returns beats 3 and 4.
- Write with aw_l=3 but w_l asserted on beat 2 -> o_err=1 and stays set; burst still completes after 4 beats with a b response.
- Assert reset_n mid-read on beat 2 of 4 -> o_r_v=0 and o_busy=0 while reset_n=1; after release, a fresh read returns correct data.

Source files
------------

// File: rtl/cory_axi_ram_pkg.sv
// rtl/cory_axi_ram_pkg.sv - shared FSM encoding, arbitration constants and byte-offset helper for cory_axi_ram
package cory_axi_ram_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WR    = 2'd1;
  localparam logic [1:0] ST_WRESP = 2'd2;
  localparam logic [1:0] ST_RD    = 2'd3;

  // Side that wins when aw and ar are both valid in IDLE
  localparam logic PRI_WRITE = 1'b0;
  localparam logic PRI_READ  = 1'b1;

  function automatic int calc_bl(input int d);
    return $clog2(d / 8);
  endfunction

endpackage

// File: rtl/cory_axi_ram_if.sv
// rtl/cory_axi_ram_if.sv - AW/W/B/AR/R channel bundle; byte strobes present only with CORY_AXI_RAM_WSTRB_EN
interface cory_axi_ram_if #(
  parameter int A = 32,
  parameter int D = 64,
  parameter int L = 4
);
  logic         i_aw_v;
  logic [A-1:0] i_aw_a;
  logic [L-1:0] i_aw_l;
  logic         o_aw_r;
  logic         i_w_v;
  logic [D-1:0] i_w_d;
  logic         i_w_l;
  logic         o_w_r;
`ifdef CORY_AXI_RAM_WSTRB_EN
  logic [D/8-1:0] i_w_s;
`endif
  logic         o_b_v;
  logic         i_b_r;
  logic         i_ar_v;
  logic [A-1:0] i_ar_a;
  logic [L-1:0] i_ar_l;
  logic         o_ar_r;
  logic         o_r_v;
  logic [D-1:0] o_r_d;
  logic         o_r_l;
  logic         i_r_r;
  logic         o_busy;
  logic         o_err;

  modport master (
`ifdef CORY_AXI_RAM_WSTRB_EN
    output i_w_s,
`endif
    output i_aw_v, i_aw_a, i_aw_l, i_w_v, i_w_d, i_w_l, i_b_r,
    output i_ar_v, i_ar_a, i_ar_l, i_r_r,
    input  o_aw_r, o_w_r, o_b_v, o_ar_r, o_r_v, o_r_d, o_r_l, o_busy, o_err
  );

  modport slave (
`ifdef CORY_AXI_RAM_WSTRB_EN
    input  i_w_s,
`endif
    input  i_aw_v, i_aw_a, i_aw_l, i_w_v, i_w_d, i_w_l, i_b_r,
    input  i_ar_v, i_ar_a, i_ar_l, i_r_r,
    output o_aw_r, o_w_r, o_b_v, o_ar_r, o_r_v, o_r_d, o_r_l, o_busy, o_err
  );
endinterface

// File: rtl/cory_axi_ram_mem.sv
// rtl/cory_axi_ram_mem.sv - 2^M x D storage, byte-enabled write port and registered read port
module cory_axi_ram_mem #(
  parameter int D = 64,
  parameter int M = 10
) (
  input  logic           clk,
  input  logic           we,
  input  logic [M-1:0]   waddr,
  input  logic [D-1:0]   wdata,
  input  logic [D/8-1:0] wbe,
  input  logic           re,
  input  logic [M-1:0]   raddr,
  output logic [D-1:0]   rdata
);
  logic [D-1:0] mem [2**M];

  // No reset on the array or read register so this maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < D / 8; k++) begin
        if (wbe[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/cory_axi_ram.sv
// rtl/cory_axi_ram.sv - one-burst-at-a-time AXI-style RAM slave; CORY_AXI_RAM_WSTRB_EN enables byte strobes
module cory_axi_ram
  import cory_axi_ram_pkg::*;
#(
  parameter int A = 32,
  parameter int D = 64,
  parameter int L = 4,
  parameter int M = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  cory_axi_ram_if.slave    bus
);
  localparam int BL = calc_bl(D);

  logic [1:0]     state;
  logic [M-1:0]   idx;
  logic [L-1:0]   len;
  logic [L-1:0]   cnt;
  logic           pri;
  logic           err;
  logic           idle;
  logic           at_last;
  logic           aw_fire, ar_fire, w_fire, b_fire, r_fire;
  logic [M-1:0]   aw_idx, ar_idx;
  logic [D-1:0]   rdata;
  logic [D/8-1:0] wbe;
  logic           unused_addr_bits;

  assign idle    = (state == ST_IDLE);
  assign at_last = (cnt == len);
  assign aw_idx  = bus.i_aw_a[BL+M-1:BL];
  assign ar_idx  = bus.i_ar_a[BL+M-1:BL];
  assign unused_addr_bits = ^{bus.i_aw_a[BL-1:0], bus.i_aw_a[A-1:BL+M],
                              bus.i_ar_a[BL-1:0], bus.i_ar_a[A-1:BL+M]};

  assign bus.o_aw_r = idle && bus.i_aw_v && (!bus.i_ar_v || pri == PRI_WRITE);
  assign bus.o_ar_r = idle && bus.i_ar_v && (!bus.i_aw_v || pri == PRI_READ);
  assign bus.o_w_r  = (state == ST_WR);
  assign bus.o_b_v  = (state == ST_WRESP);
  assign bus.o_r_v  = (state == ST_RD);
  assign bus.o_r_l  = bus.o_r_v && at_last;
  // The read register is not reset, so mask it to keep o_r_d at 0 outside RD
  assign bus.o_r_d  = bus.o_r_v ? rdata : '0;
  assign bus.o_busy = !idle;
  assign bus.o_err  = err;

  assign aw_fire = bus.i_aw_v && bus.o_aw_r;
  assign ar_fire = bus.i_ar_v && bus.o_ar_r;
  assign w_fire  = bus.i_w_v  && bus.o_w_r;
  assign b_fire  = bus.o_b_v  && bus.i_b_r;
  assign r_fire  = bus.o_r_v  && bus.i_r_r;

`ifdef CORY_AXI_RAM_WSTRB_EN
  assign wbe = bus.i_w_s;
`else
  assign wbe = '1;
`endif

  cory_axi_ram_mem #(.D(D), .M(M)) u_mem (
    .clk   (clk),
    .we    (w_fire),
    .waddr (idx),
    .wdata (bus.i_w_d),
    .wbe   (wbe),
    .re    (ar_fire || (r_fire && !at_last)),
    .raddr (ar_fire ? ar_idx : idx),
    .rdata (rdata)
  );

  // On read, idx runs one word ahead of the beat on o_r_d so the next word
  // can be fetched in the same cycle the current one is accepted.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      len   <= '0;
      cnt   <= '0;
      pri   <= PRI_WRITE;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aw_fire) begin
            state <= ST_WR;
            idx   <= aw_idx;
            len   <= bus.i_aw_l;
            cnt   <= '0;
            pri   <= PRI_READ;
          end else if (ar_fire) begin
            state <= ST_RD;
            idx   <= ar_idx + M'(1);
            len   <= bus.i_ar_l;
            cnt   <= '0;
            pri   <= PRI_WRITE;
          end
        end
        ST_WR: begin
          if (w_fire) begin
            idx <= idx + M'(1);
            cnt <= cnt + L'(1);
            if (bus.i_w_l != at_last) err <= 1'b1;
            if (at_last) state <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (b_fire) state <= ST_IDLE;
        end
        ST_RD: begin
          if (r_fire) begin
            if (at_last) begin
              state <= ST_IDLE;
            end else begin
              idx <= idx + M'(1);
              cnt <= cnt + L'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cory_axi_ram.sv
// tb/tb_cory_axi_ram.sv - table-driven write/read-back bench with read scoreboard for cory_axi_ram
module tb_cory_axi_ram;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  cory_axi_ram_if #(.A(32), .D(64), .L(4)) bus ();

  cory_axi_ram #(.A(32), .D(64), .L(4), .M(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [63:0] d;
    logic        l;
  } rexp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [63:0] seed;
    logic        toggle;
    logic        exp_err;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          b_seen = 0;
  logic [63:0] model [1024];
  rexp_t       exp_q [$];
  rexp_t       cur;
  vec_t        vecs [4];
  logic        prev_stall = 1'b0;
  logic        prev_cont = 1'b0;
  logic [63:0] prev_d;
  logic        prev_l;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      prev_stall = 1'b0;
      prev_cont  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("r_hold_d", bus.o_r_d, prev_d);
        check("r_hold_l", {63'd0, bus.o_r_l}, {63'd0, prev_l});
      end
      if (prev_cont) check("r_v_continuous", {63'd0, bus.o_r_v}, 64'd1);
      if (bus.i_aw_v && bus.i_ar_v)
        check("aw_ar_exclusive", {63'd0, bus.o_aw_r && bus.o_ar_r}, 64'd0);
      if (bus.o_r_v && bus.i_r_r) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL r_unexpected: got beat %0h with empty scoreboard", bus.o_r_d);
        end else begin
          cur = exp_q.pop_front();
          check("r_data", bus.o_r_d, cur.d);
          check("r_last", {63'd0, bus.o_r_l}, {63'd0, cur.l});
        end
      end
      if (bus.o_b_v && bus.i_b_r) b_seen++;
      prev_stall = bus.o_r_v && !bus.i_r_r;
      prev_d     = bus.o_r_d;
      prev_l     = bus.o_r_l;
      prev_cont  = bus.o_r_v && bus.i_r_r && !bus.o_r_l;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int which, input string name);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 64) begin
      @(negedge clk);
      case (which)
        0:       hit = bus.o_aw_r;
        1:       hit = bus.o_ar_r;
        2:       hit = bus.o_w_r;
        default: hit = bus.o_b_v;
      endcase
      @(posedge clk);
      #1;
      n++;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: no handshake after %0d cycles, required within 64", name, n);
    end
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] len,
                             input logic [63:0] seed, input int bad_last);
    logic [9:0] wi;
    int b0;
    bus.i_aw_v = 1'b1;
    bus.i_aw_a = addr;
    bus.i_aw_l = len;
    wait_ready(0, "aw_ready");
    bus.i_aw_v = 1'b0;
    wi = addr[12:3];
    for (int i = 0; i <= int'(len); i++) begin
      bus.i_w_v = 1'b1;
      bus.i_w_d = seed + 64'(i);
      bus.i_w_l = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
      wait_ready(2, "w_ready");
      model[wi] = seed + 64'(i);
      wi = wi + 10'd1;
    end
    bus.i_w_v = 1'b0;
    bus.i_w_l = 1'b0;
    b0 = b_seen;
    bus.i_b_r = 1'b1;
    wait_ready(3, "b_valid");
    bus.i_b_r = 1'b0;
    tick();
    check("b_count", 64'(b_seen - b0), 64'd1);
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] len, input logic toggle);
    logic [9:0] wi;
    int n = 0;
    wi = addr[12:3];
    for (int i = 0; i <= int'(len); i++) begin
      exp_q.push_back('{d: model[wi], l: (i == int'(len))});
      wi = wi + 10'd1;
    end
    bus.i_r_r  = 1'b1;
    bus.i_ar_v = 1'b1;
    bus.i_ar_a = addr;
    bus.i_ar_l = len;
    wait_ready(1, "ar_ready");
    bus.i_ar_v = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
      if (toggle) bus.i_r_r = !bus.i_r_r;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL r_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    bus.i_r_r = 1'b0;
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_aw_r"}, {63'd0, bus.o_aw_r}, 64'd0);
    check({tag, "_ar_r"}, {63'd0, bus.o_ar_r}, 64'd0);
    check({tag, "_w_r"},  {63'd0, bus.o_w_r},  64'd0);
    check({tag, "_b_v"},  {63'd0, bus.o_b_v},  64'd0);
    check({tag, "_r_v"},  {63'd0, bus.o_r_v},  64'd0);
    check({tag, "_r_l"},  {63'd0, bus.o_r_l},  64'd0);
    check({tag, "_r_d"},  bus.o_r_d,           64'd0);
    check({tag, "_busy"}, {63'd0, bus.o_busy}, 64'd0);
  endtask

  initial begin
    int g;
    int n;
    int grants [4];
    int b0;

    bus.i_aw_v = 1'b0; bus.i_aw_a = '0; bus.i_aw_l = '0;
    bus.i_w_v  = 1'b0; bus.i_w_d  = '0; bus.i_w_l  = 1'b0;
    bus.i_b_r  = 1'b0;
    bus.i_ar_v = 1'b0; bus.i_ar_a = '0; bus.i_ar_l = '0;
    bus.i_r_r  = 1'b0;
`ifdef CORY_AXI_RAM_WSTRB_EN
    bus.i_w_s  = '1;
`endif

    vecs[0] = '{addr: 32'h0000_0100, len: 4'd3, seed: 64'd1,                  toggle: 1'b0, exp_err: 1'b0};
    vecs[1] = '{addr: 32'h0000_0800, len: 4'd7, seed: 64'hDEAD_0000_0000_0010, toggle: 1'b1, exp_err: 1'b0};
    vecs[2] = '{addr: 32'h0000_1FF0, len: 4'd3, seed: 64'h1000,               toggle: 1'b0, exp_err: 1'b0};
    vecs[3] = '{addr: 32'h0000_0208, len: 4'd0, seed: 64'hCAFE,               toggle: 1'b0, exp_err: 1'b0};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_err", {63'd0, bus.o_err}, 64'd0);
    tick();
    reset_n = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      write_burst(vecs[v].addr, vecs[v].len, vecs[v].seed, -1);
      read_burst(vecs[v].addr, vecs[v].len, vecs[v].toggle);
      @(negedge clk);
      check("vec_err", {63'd0, bus.o_err}, {63'd0, vecs[v].exp_err});
      check("vec_busy", {63'd0, bus.o_busy}, 64'd0);
      tick();
    end

    // Wrapped burst landed in words 0 and 1 as its 3rd and 4th beats
    exp_q.push_back('{d: 64'h1002, l: 1'b0});
    exp_q.push_back('{d: 64'h1003, l: 1'b1});
    bus.i_r_r  = 1'b1;
    bus.i_ar_v = 1'b1;
    bus.i_ar_a = 32'h0;
    bus.i_ar_l = 4'd1;
    wait_ready(1, "ar_ready_wrap");
    bus.i_ar_v = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("wrap_beats_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    bus.i_r_r = 1'b0;
    tick();

    write_burst(32'h0000_0300, 4'd3, 64'h50, 1);
    @(negedge clk);
    check("err_set", {63'd0, bus.o_err}, 64'd1);
    tick();
    write_burst(32'h0000_0300, 4'd0, 64'h90, -1);
    read_burst(32'h0000_0300, 4'd3, 1'b0);
    @(negedge clk);
    check("err_sticky", {63'd0, bus.o_err}, 64'd1);
    tick();

    for (int i = 0; i < 4; i++) exp_q.push_back('{d: model[256 + i], l: (i == 3)});
    bus.i_r_r  = 1'b1;
    bus.i_ar_v = 1'b1;
    bus.i_ar_a = 32'h0000_0800;
    bus.i_ar_l = 4'd3;
    wait_ready(1, "ar_ready_rst");
    bus.i_ar_v = 1'b0;
    n = 0;
    while (exp_q.size() > 3 && n < 20) begin
      tick();
      n++;
    end
    check("rst_beats_before", 64'(exp_q.size()), 64'd3);
    reset_n = 1'b1;
    exp_q.delete();
    bus.i_r_r = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    check("midrst_err", {63'd0, bus.o_err}, 64'd0);
    tick();
    reset_n = 1'b0;
    tick();
    read_burst(32'h0000_0800, 4'd3, 1'b0);

    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    bus.i_w_v  = 1'b1; bus.i_w_d = 64'h77; bus.i_w_l = 1'b1;
    bus.i_b_r  = 1'b1; bus.i_r_r = 1'b1;
    bus.i_aw_a = 32'h40;  bus.i_aw_l = 4'd0;
    bus.i_ar_a = 32'h208; bus.i_ar_l = 4'd0;
    bus.i_aw_v = 1'b1;    bus.i_ar_v = 1'b1;
    b0 = b_seen;
    g = 0;
    n = 0;
    while (g < 4 && n < 200) begin
      @(negedge clk);
      if (bus.o_aw_r) begin
        grants[g] = 0;
        g++;
        model[8] = 64'h77;
      end else if (bus.o_ar_r) begin
        grants[g] = 1;
        g++;
        exp_q.push_back('{d: model[65], l: 1'b1});
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.i_aw_v = 1'b0;
    bus.i_ar_v = 1'b0;
    check("arb_grant_count", 64'(g), 64'd4);
    for (int i = 0; i < 4; i++) check("arb_grant_order", 64'(grants[i]), 64'(i % 2));
    repeat (4) tick();
    check("arb_b_count", 64'(b_seen - b0), 64'd2);
    check("arb_beats_left", 64'(exp_q.size()), 64'd0);
    bus.i_w_v = 1'b0; bus.i_w_l = 1'b0; bus.i_b_r = 1'b0; bus.i_r_r = 1'b0;
    @(negedge clk);
    check("final_busy", {63'd0, bus.o_busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
